// File: rtl/ara_pkg.sv
// Shared definitions for the vector lane datapath.
// Holds the element/instruction-id types and the writeback source enum used by
// the per-lane result arbiter. The writeback request struct depends on the
// address type, which is a module parameter, so it is declared locally inside
// vfu_result_arbiter rather than here.
package ara_pkg;

    localparam int unsigned ELEN    = 64;
    localparam int unsigned NrVInsn = 8;

    typedef logic [ELEN-1:0]            elen_t;
    typedef logic [$clog2(NrVInsn)-1:0] vid_t;

    // Result sources competing for the lane VRF write port
    typedef enum logic {
        WbSrcAlu  = 1'b0,
        WbSrcMfpu = 1'b1
    } vfu_wb_src_e;

endpackage

// File: rtl/vfu_wb_fifo.sv
// Small FIFO with occupancy count, one per writeback source.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, data_i    write one entry (caller guarantees not full)
//   pop_i             drop the head entry (caller guarantees not empty)
//   data_o            current head entry
//   empty_o           no entries stored
//   count_o           number of stored entries, 0..Depth
module vfu_wb_fifo #(
    parameter int unsigned Depth  = 2,
    parameter type         data_t = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  data_t                        data_i,
    input  logic                         pop_i,
    output data_t                        data_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth+1);

    data_t             mem_r [Depth];
    logic [PtrW-1:0]   wr_ptr_r;
    logic [PtrW-1:0]   rd_ptr_r;
    logic [CntW-1:0]   count_r;
    logic              push_s;
    logic              pop_s;

    // Pointers wrap at Depth, which need not be a power of two
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end else begin
            return ptr + PtrW'(1);
        end
    endfunction

    assign push_s  = push_i & (count_r != CntW'(Depth));
    assign pop_s   = pop_i & (count_r != CntW'(0));
    assign data_o  = mem_r[rd_ptr_r];
    assign empty_o = (count_r == CntW'(0));
    assign count_o = count_r;

    // Storage array; contents are don't-care while unoccupied
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/vfu_result_arbiter.sv
// Per-lane writeback stage: buffers ALU and MFPU results in separate FIFOs and
// round-robins them onto the single lane VRF write port through an output
// register, so one unit waiting on the VRF does not stall the other.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   alu_result_*  / mfpu_result_* request fields in, gnt out (combinational,
//                                asserted when the source FIFO has room)
//   vrf_*                        registered write presented to the VRF, held
//                                until vrf_gnt_i
//   idle_o                       nothing buffered and no write presented
module vfu_result_arbiter
    import ara_pkg::*;
#(
    parameter int unsigned NrLanes   = 0,
    parameter type         vaddr_t   = logic,
    parameter int unsigned BufDepth  = 2,
    parameter int unsigned DataWidth = $bits(elen_t)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alu_result_req_i,
    input  vid_t                   alu_result_id_i,
    input  vaddr_t                 alu_result_addr_i,
    input  logic [DataWidth-1:0]   alu_result_wdata_i,
    input  logic [DataWidth/8-1:0] alu_result_be_i,
    output logic                   alu_result_gnt_o,
    input  logic                   mfpu_result_req_i,
    input  vid_t                   mfpu_result_id_i,
    input  vaddr_t                 mfpu_result_addr_i,
    input  logic [DataWidth-1:0]   mfpu_result_wdata_i,
    input  logic [DataWidth/8-1:0] mfpu_result_be_i,
    output logic                   mfpu_result_gnt_o,
    output logic                   vrf_req_o,
    output vid_t                   vrf_id_o,
    output vaddr_t                 vrf_addr_o,
    output logic [DataWidth-1:0]   vrf_wdata_o,
    output logic [DataWidth/8-1:0] vrf_be_o,
    input  logic                   vrf_gnt_i,
    output logic                   idle_o
);

    localparam int unsigned CntW = $clog2(BufDepth+1);

    // Reject unsupported configurations at elaboration time
    if (BufDepth < 1 || BufDepth > 4 || DataWidth != $bits(elen_t) || NrLanes > 1024) begin : g_bad_cfg
        $error("vfu_result_arbiter: unsupported parameter combination");
    end

    typedef struct packed {
        vid_t                   id;
        vaddr_t                 addr;
        logic [DataWidth-1:0]   wdata;
        logic [DataWidth/8-1:0] be;
    } vfu_wb_req_t;

    vfu_wb_req_t     alu_head_s,  mfpu_head_s;
    logic            alu_empty_s, mfpu_empty_s;
    logic [CntW-1:0] alu_count_s, mfpu_count_s;
    logic            alu_pop_s,   mfpu_pop_s;
    logic            load_s;
    logic            any_s;
    vfu_wb_src_e     winner_s;
    vfu_wb_req_t     next_out_s;

    logic            out_valid_r;
    vfu_wb_req_t     out_data_r;
    vfu_wb_src_e     last_winner_r;

    // A full FIFO refuses even if it pops this cycle: no full-bypass path
    assign alu_result_gnt_o  = alu_result_req_i  & ~rst_i & (alu_count_s  < CntW'(BufDepth));
    assign mfpu_result_gnt_o = mfpu_result_req_i & ~rst_i & (mfpu_count_s < CntW'(BufDepth));

    vfu_wb_fifo #(.Depth(BufDepth), .data_t(vfu_wb_req_t)) i_alu_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (alu_result_gnt_o),
        .data_i  ({alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i}),
        .pop_i   (alu_pop_s),
        .data_o  (alu_head_s),
        .empty_o (alu_empty_s),
        .count_o (alu_count_s)
    );

    vfu_wb_fifo #(.Depth(BufDepth), .data_t(vfu_wb_req_t)) i_mfpu_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (mfpu_result_gnt_o),
        .data_i  ({mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i}),
        .pop_i   (mfpu_pop_s),
        .data_o  (mfpu_head_s),
        .empty_o (mfpu_empty_s),
        .count_o (mfpu_count_s)
    );

    // Round-robin pick: on a tie the source that did not win last time goes
    always_comb begin
        load_s     = ~out_valid_r | vrf_gnt_i;
        any_s      = ~alu_empty_s | ~mfpu_empty_s;
        winner_s   = WbSrcAlu;
        next_out_s = '0;
        if (!alu_empty_s && !mfpu_empty_s) begin
            winner_s = (last_winner_r == WbSrcMfpu) ? WbSrcAlu : WbSrcMfpu;
        end else if (!mfpu_empty_s) begin
            winner_s = WbSrcMfpu;
        end else begin
            winner_s = WbSrcAlu;
        end
        if (any_s) begin
            case (winner_s)
                WbSrcAlu:  next_out_s = alu_head_s;
                WbSrcMfpu: next_out_s = mfpu_head_s;
                default:   next_out_s = alu_head_s;
            endcase
        end else begin
            next_out_s = '0;
        end
        alu_pop_s  = load_s & any_s & (winner_s == WbSrcAlu);
        mfpu_pop_s = load_s & any_s & (winner_s == WbSrcMfpu);
    end

    // Output register: refills whenever empty or its write was accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            last_winner_r <= WbSrcMfpu;
        end else if (load_s) begin
            out_valid_r <= any_s;
            out_data_r  <= next_out_s;
            if (any_s) begin
                last_winner_r <= winner_s;
            end
        end
    end

    assign vrf_req_o   = out_valid_r;
    assign vrf_id_o    = out_data_r.id;
    assign vrf_addr_o  = out_data_r.addr;
    assign vrf_wdata_o = out_data_r.wdata;
    assign vrf_be_o    = out_data_r.be;
    assign idle_o      = ~out_valid_r & alu_empty_s & mfpu_empty_s;

endmodule
